// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a 1-cycle synchronous instruction memory
// and produces the registered IF/ID instruction, its PC and a bubble flag.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hlt,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        bubble,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         bubble_q, bubble_d;

  // Targets are word aligned; the low two bits of redirect_pc are dropped.
  logic redirect_lsb_unused;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_d      = state_q;
    fpc_d        = fpc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    bubble_d     = bubble_q;

    if (redirect) begin
      state_d      = RUN;
      fpc_d        = {redirect_pc[31:2], 2'b00};
      pend_valid_d = 1'b0;
      instr_d      = NOP;
      bubble_d     = 1'b1;
    end else if (state_q == RUN) begin
      if (hlt) begin
        state_d      = HALTED;
        pend_valid_d = 1'b0;
        instr_d      = NOP;
        bubble_d     = 1'b1;
      end else if (!stall) begin
        // The word for pend_pc arrives this cycle; fpc is being read now.
        instr_d      = pend_valid_q ? imem_rdata : NOP;
        pc_out_d     = pend_pc_q;
        bubble_d     = ~pend_valid_q;
        pend_pc_d    = fpc_q;
        pend_valid_d = 1'b1;
        fpc_d        = fpc_q + 32'd4;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      fpc_q        <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
      instr_q      <= NOP;
      pc_out_q     <= RESET_PC;
      bubble_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      bubble_q     <= bubble_d;
    end
  end

  // Memory holds its output while disabled, which keeps the pending word alive.
  assign imem_en     = (state_q == RUN) & ~stall & ~rst;
  assign imem_addr   = fpc_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign bubble      = bubble_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios, then random
// control traffic compared against a queue-based reference model.
module tb_instr_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        hlt = 1'b0;

  logic [31:0] imem_addr, imem_rdata, instruction, pc_out;
  logic        imem_en, bubble, halted;
  logic [31:0] imem_addr2, imem_rdata2, instruction2, pc_out2;
  logic        imem_en2, bubble2, halted2;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[7:0] ^ 8'h5A, a[31:8]} + 32'h1357_9BDF;
  endfunction

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RPC_A)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .hlt(hlt), .instruction(instruction),
    .pc_out(pc_out), .bubble(bubble), .halted(halted)
  );

  instr_fetch #(.RESET_PC(RPC_B)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_en(imem_en2),
    .imem_rdata(imem_rdata2), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .hlt(hlt), .instruction(instruction2),
    .pc_out(pc_out2), .bubble(bubble2), .halted(halted2)
  );

  // Synchronous-read instruction memories; output held while disabled.
  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= mem_word(imem_addr);
    if (imem_en2) imem_rdata2 <= mem_word(imem_addr2);
  end

  // Reference model: fetch address, in-flight fetch queue, decoder-side view.
  logic [31:0] m_fpc = RPC_A;
  logic [31:0] m_last = RPC_A;
  logic [31:0] m_instr = NOP_W;
  logic [31:0] m_pc = RPC_A;
  logic        m_bub = 1'b1;
  logic        m_halted = 1'b0;
  logic [31:0] inflight [$];

  task automatic model_edge(input logic r, rd, input logic [31:0] rpc,
                            input logic h, s);
    logic [31:0] a;
    if (r) begin
      m_fpc = RPC_A; m_last = RPC_A; inflight.delete();
      m_instr = NOP_W; m_pc = RPC_A; m_bub = 1'b1; m_halted = 1'b0;
    end else if (rd) begin
      m_fpc = rpc & 32'hFFFF_FFFC; inflight.delete();
      m_instr = NOP_W; m_bub = 1'b1; m_halted = 1'b0;
    end else if (m_halted) begin
      // frozen until reset or redirect
    end else if (h) begin
      m_halted = 1'b1; inflight.delete(); m_instr = NOP_W; m_bub = 1'b1;
    end else if (!s) begin
      if (inflight.size() > 0) begin
        a = inflight.pop_front();
        m_instr = mem_word(a); m_pc = a; m_bub = 1'b0;
      end else begin
        m_instr = NOP_W; m_pc = m_last; m_bub = 1'b1;
      end
      inflight.push_back(m_fpc);
      m_last = m_fpc;
      m_fpc = m_fpc + 32'd4;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, check the memory request, clock, check IF/ID.
  task automatic cyc(input logic r, rd, input logic [31:0] rpc, input logic h, s);
    rst = r; redirect = rd; redirect_pc = rpc; hlt = h; stall = s;
    #1;
    check("imem_en", {31'd0, imem_en}, {31'd0, !m_halted && !s && !r});
    check("imem_addr", imem_addr, m_fpc);
    @(posedge clk);
    model_edge(r, rd, rpc, h, s);
    #1;
    check("instruction", instruction, m_instr);
    check("pc_out", pc_out, m_pc);
    check("bubble", {31'd0, bubble}, {31'd0, m_bub});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
  endtask

  initial begin
    mem_ovr[32'h0000_0000] = 32'h0050_0093;
    mem_ovr[32'h0000_0004] = 32'h00A0_0113;
    mem_ovr[32'h0000_0100] = 32'h0000_007F;

    // Reset wins over concurrent redirect, halt and stall.
    @(posedge clk); #1;
    cyc(1, 1, 32'h80, 1, 1);
    cyc(1, 1, 32'h80, 1, 1);
    check("rst_instr", instruction, NOP_W);
    check("rst_pc", pc_out, RPC_A);
    check("rst_bubble", {31'd0, bubble}, 32'd1);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);

    // Reset release: one bubble, then mem[0], mem[4].
    cyc(0, 0, 0, 0, 0);
    check("rel_bubble", {31'd0, bubble}, 32'd1);
    check("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    check("rel_instr0", instruction, 32'h0050_0093);
    check("rel_pc0", pc_out, 32'h0);
    check("wrap_addr2", imem_addr2, 32'h0000_0000);
    cyc(0, 0, 0, 0, 0);
    check("rel_instr1", instruction, 32'h00A0_0113);
    check("rel_pc1", pc_out, 32'h4);

    // Stall mid-stream for three cycles, then resume.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

    // Redirect alongside stall: aligned target, two bubbles, then the target.
    cyc(0, 1, 32'h0000_0042, 0, 1);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_bub0", {31'd0, bubble}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    check("redir_bub1", {31'd0, bubble}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    check("redir_valid", {31'd0, bubble}, 32'd0);
    check("redir_pc", pc_out, 32'h40);

    // Halt on 0x7F, stay halted for 10 cycles, leave via redirect.
    cyc(0, 1, 32'h100, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("hlt_instr", instruction, 32'h0000_007F);
    cyc(0, 0, 0, 1, 0);
    check("hlt_halted", {31'd0, halted}, 32'd1);
    check("hlt_bubble", {31'd0, bubble}, 32'd1);
    check("hlt_en", {31'd0, imem_en}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("hlt_stay", {31'd0, halted}, 32'd1);
    end
    cyc(0, 1, 32'h200, 0, 0);
    check("hlt_exit", {31'd0, halted}, 32'd0);

    // Reset while halted discards everything.
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    check("hlt_rst", {31'd0, halted}, 32'd0);

    // Random control traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, rd, h, s;
      logic [31:0] rpc;
      r   = ($urandom_range(63) == 0);
      rd  = ($urandom_range(15) == 0);
      h   = ($urandom_range(31) == 0);
      s   = ($urandom_range(3) == 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : $urandom;
      cyc(r, rd, rpc, h, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have one parameter: RESET_PC, 32'h0000_0000, byte address fetched first after reset.
REQ-002 The module SHALL have one clock; reset is synchronous and active-high; the ports SHALL be named clk and rst.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port imem_addr SHALL be an output, 32 bits wide: byte address to instruction memory; equals fpc.
REQ-006 Port imem_en SHALL be an output, 1 bit wide: read enable; memory holds imem_rdata when imem_en=0.
REQ-007 Port imem_rdata SHALL be an input, 32 bits wide: word at the previous cycle's imem_addr (1-cycle synchronous read).
REQ-008 Port stall SHALL be an input, 1 bit wide: hold the decode stage and all fetch state.
REQ-009 Port redirect SHALL be an input, 1 bit wide: a taken branch, jal or jalr resolved downstream.
REQ-010 Port redirect_pc SHALL be an input, 32 bits wide: redirect target.
REQ-011 Port hlt SHALL be an input, 1 bit wide: the decoder's halt signal for the current output instruction.
REQ-012 Port instruction SHALL be an output, 32 bits wide: registered IF/ID instruction to the decoder.
REQ-013 Port pc_out SHALL be an output, 32 bits wide: address of instruction.
REQ-014 Port bubble SHALL be an output, 1 bit wide: instruction is not valid and the decoder must suppress control signals.
REQ-015 Port halted SHALL be an output, 1 bit wide: the fetch unit is in HALTED.

Function
REQ-016 Internal state SHALL be: fpc (32-bit), pend_valid, pend_pc (32-bit), IF/ID register {instruction, pc_out, bubble}, and FSM state {RUN, HALTED}.
REQ-017 Event priority SHALL be rst > redirect > hlt > stall > normal advance.
REQ-018 On a normal advance (RUN, no rst/redirect/hlt/stall): instruction<=pend_valid?imem_rdata:NOP; pc_out<=pend_pc; bubble<=~pend_valid; pend_pc<=fpc; pend_valid<=1; fpc<=fpc+4.
REQ-019 The fpc increment SHALL be modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-020 imem_en SHALL equal (state==RUN)&~stall&~rst.
REQ-021 On stall, all registers SHALL hold their values, so the memory word for pend_pc remains valid on imem_rdata.
REQ-022 On redirect: fpc<=redirect_pc with bits[1:0] forced to 00; pend_valid<=0; instruction<=NOP; bubble<=1; pc_out is held.
REQ-023 Redirect SHALL be honoured regardless of stall, and also in HALTED, in which case state<=RUN.
REQ-024 The first valid instruction after a redirect SHALL appear 2 cycles after the redirect edge; exactly 2 bubbles are inserted.
REQ-025 On hlt in RUN: state<=HALTED; pend_valid<=0; instruction<=NOP; bubble<=1; fpc is held.
REQ-026 In HALTED, all registers SHALL hold their values; halted=1; imem_en=0.
REQ-027 Latency from imem_addr=A (with imem_en=1) to instruction=mem[A] SHALL be 2 cycles.
REQ-028 NOP SHALL be 32'h0000_0013 (addi x0,x0,0).

Reset
REQ-029 On rst=1 at a clock edge: fpc<=RESET_PC; pend_valid<=0; pend_pc<=RESET_PC; instruction<=NOP; pc_out<=RESET_PC; bubble<=1; state<=RUN; halted=0.
REQ-030 Reset SHALL override all concurrent redirect, hlt and stall inputs.
REQ-031 Reset asserted mid-operation, including in HALTED or with a pending redirect, SHALL discard all in-flight fetches.

Structure
REQ-032 The shared package SHALL hold the NOP constant, the fetch_state_t enum {RUN, HALTED} and the default RESET_PC.
REQ-033 The module SHALL be a single module with no sub-module; the PC adder and IF/ID register are inline.

Verification
REQ-034 Scenario: reset release with mem[0]=0x00500093, mem[4]=0x00A00113 -> bubble=1 for cycle 1; instruction=0x00500093 with pc_out=0 on cycle 2; 0x00A00113 with pc_out=4 on cycle 3.
REQ-035 Scenario: stall held for 3 cycles mid-stream -> instruction, pc_out and imem_addr are unchanged; the stream resumes with no lost or duplicated instruction.
REQ-036 Scenario: redirect_pc=0x0000_0042 asserted together with stall -> imem_addr=0x40 next cycle; 2 bubbles; then pc_out=0x40.
REQ-037 Scenario: hlt=1 while instruction=0x0000007F -> next cycle halted=1, bubble=1, imem_en=0; the module stays halted for 10 cycles; a later redirect returns it to RUN.
REQ-038 Scenario: RESET_PC=0xFFFF_FFF8 -> fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-039 Scenario: rst, redirect and hlt asserted in the same cycle -> reset state per REQ-029.
